asym_dual_ram_sc: RTL and testbench

//  Single-clock, width-asymmetric dual-port RAM. Next generation of the team's dual_ram.

---
 rtl/dual_ram_pkg.sv | 21 ++
 rtl/dual_ram_core.sv | 44 ++++
 rtl/asym_dual_ram_sc.sv | 229 ++++++++++++++++++++++
 tb/tb_asym_dual_ram_sc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_ram_pkg.sv
// Shared types and helpers for the width-asymmetric dual-port RAM family.
// Holds the port-B sequencer state encoding and small sizing/slicing helpers.
package dual_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_B  = 2'd1,
    RD_B  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Counter width that never collapses to zero bits when the ratio is 1.
  function automatic int clog2_safe(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sub_lo(input int k, input int dwa);
    return k * dwa;
  endfunction

endpackage

// File: rtl/dual_ram_core.sv
// 1-write / 2-read narrow storage array with registered read ports.
// The array itself is never reset; only the read registers are.
module dual_ram_core #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en_a,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic          rd_en_b,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Reads sample the array before this edge's write lands, so a same-address
  // read and write in one cycle returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (rd_en_a) begin
        rd_data_a <= mem[rd_addr_a];
      end
      if (rd_en_b) begin
        rd_data_b <= mem[rd_addr_b];
      end
    end
  end

endmodule

// File: rtl/asym_dual_ram_sc.sv
// Single-clock width-asymmetric dual-port RAM: narrow random port A, wide handshaked port B.
// Optional power-on clear of the array is enabled by defining DUAL_RAM_CLEAR_EN.
module asym_dual_ram_sc
  import dual_ram_pkg::*;
#(
  parameter  int DWA     = 16,
  parameter  int AWA     = 6,
  parameter  int MULTNUM = 4,
  localparam int DWB     = DWA * MULTNUM,
  localparam int AWB     = AWA - $clog2(MULTNUM)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DWA-1:0] i_data_a,
  input  logic [AWA-1:0] i_addr_a,
  input  logic           i_wr_en_a,
  input  logic           i_rd_en_a,
  output logic [DWA-1:0] o_data_a,
  output logic           o_rd_valid_a,
  input  logic           i_req_b,
  input  logic           i_wr_en_b,
  input  logic [AWB-1:0] i_addr_b,
  input  logic [DWB-1:0] i_data_b,
  output logic           o_ready_b,
  output logic [DWB-1:0] o_data_b,
  output logic           o_rd_valid_b,
  output logic           o_wr_done_b,
  output logic           o_conflict,
  output logic           o_init_done
);

  localparam int            CW   = clog2_safe(MULTNUM);
  localparam int            LOGM = $clog2(MULTNUM);
  localparam logic [CW-1:0] LAST = CW'(MULTNUM - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [AWB-1:0] line_q;
  logic [DWB-1:0] wdata_q;
  logic [DWB-1:0] asm_q;
  logic [DWB-1:0] asm_next;
  logic           accept;
  logic           conflict_hit;

  logic           wr_en;
  logic [AWA-1:0] wr_addr;
  logic [DWA-1:0] wr_data;
  logic           rd_en_b;
  logic [AWA-1:0] rd_addr_b;
  logic [DWA-1:0] core_rd_a;
  logic [DWA-1:0] core_rd_b;

`ifdef DUAL_RAM_CLEAR_EN
  logic [AWA-1:0] clr_addr;
  logic           init_done_q;
  logic           a_zero;
`endif

  function automatic logic [AWA-1:0] sub_addr(input logic [AWB-1:0] line,
                                              input logic [CW-1:0]  k);
    return (AWA'(line) << LOGM) | AWA'(k);
  endfunction

  assign cnt_inc      = cnt + CW'(1);
  assign accept       = i_req_b & o_ready_b;
  assign conflict_hit = i_wr_en_a && (state == WR_B || state == RD_B) &&
                        (i_addr_a[AWA-1 -: AWB] == line_q);

  // Single write port: clear sweep first, then port A, then the B sub-word.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef DUAL_RAM_CLEAR_EN
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
    end else
`endif
    if (i_wr_en_a) begin
      wr_en   = 1'b1;
      wr_addr = i_addr_a;
      wr_data = i_data_a;
    end else if (state == WR_B) begin
      wr_en   = 1'b1;
      wr_addr = sub_addr(line_q, cnt);
      wr_data = wdata_q[sub_lo(int'(cnt), DWA) +: DWA];
    end
  end

  // Sub-word 0 is fetched on the accept edge, so each RD_B cycle already
  // sees sub-word cnt and prefetches cnt+1.
  always_comb begin
    rd_en_b   = 1'b0;
    rd_addr_b = sub_addr(i_addr_b, '0);
    if (state == IDLE) begin
      rd_en_b = accept & ~i_wr_en_b;
    end else if (state == RD_B && cnt != LAST) begin
      rd_en_b   = 1'b1;
      rd_addr_b = sub_addr(line_q, cnt_inc);
    end
  end

  always_comb begin
    asm_next = asm_q;
    asm_next[sub_lo(int'(cnt), DWA) +: DWA] = core_rd_b;
  end

  dual_ram_core #(
    .DW(DWA),
    .AW(AWA)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en_a   (i_rd_en_a),
    .rd_addr_a (i_addr_a),
    .rd_data_a (core_rd_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (core_rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid_a <= 1'b0;
    end else begin
      o_rd_valid_a <= i_rd_en_a;
    end
  end

`ifdef DUAL_RAM_CLEAR_EN
  // Remembers whether the latest A read was issued mid-clear so the held
  // output stays zero until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_zero <= 1'b0;
    end else if (i_rd_en_a) begin
      a_zero <= (state == CLEAR);
    end
  end

  assign o_data_a    = a_zero ? '0 : core_rd_a;
  assign o_init_done = init_done_q;
`else
  assign o_data_a    = core_rd_a;
  assign o_init_done = 1'b1;
`endif

  // Port-B sequencer; all handshake and pulse outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      line_q       <= '0;
      wdata_q      <= '0;
      asm_q        <= '0;
      o_data_b     <= '0;
      o_rd_valid_b <= 1'b0;
      o_wr_done_b  <= 1'b0;
      o_conflict   <= 1'b0;
`ifdef DUAL_RAM_CLEAR_EN
      state        <= CLEAR;
      o_ready_b    <= 1'b0;
      clr_addr     <= '0;
      init_done_q  <= 1'b0;
`else
      state        <= IDLE;
      o_ready_b    <= 1'b1;
`endif
    end else begin
      o_rd_valid_b <= 1'b0;
      o_wr_done_b  <= 1'b0;
      o_conflict   <= conflict_hit;
      case (state)
        IDLE: begin
          if (accept) begin
            line_q    <= i_addr_b;
            wdata_q   <= i_data_b;
            cnt       <= '0;
            o_ready_b <= 1'b0;
            state     <= i_wr_en_b ? WR_B : RD_B;
          end
        end
        WR_B: begin
          if (!i_wr_en_a) begin
            if (cnt == LAST) begin
              cnt         <= '0;
              o_wr_done_b <= 1'b1;
              o_ready_b   <= 1'b1;
              state       <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        RD_B: begin
          asm_q <= asm_next;
          if (cnt == LAST) begin
            cnt          <= '0;
            o_data_b     <= asm_next;
            o_rd_valid_b <= 1'b1;
            o_ready_b    <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
`ifdef DUAL_RAM_CLEAR_EN
        CLEAR: begin
          clr_addr <= clr_addr + AWA'(1);
          if (clr_addr == {AWA{1'b1}}) begin
            init_done_q <= 1'b1;
            o_ready_b   <= 1'b1;
            state       <= IDLE;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          o_ready_b <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asym_dual_ram_sc.sv
// Directed self-checking bench for asym_dual_ram_sc (DWA=16, AWA=6, MULTNUM=4).
// Honours DUAL_RAM_CLEAR_EN when the design is built with the clear sweep enabled.
module tb_asym_dual_ram_sc;

  localparam int DWA = 16;
  localparam int AWA = 6;
  localparam int MULTNUM = 4;
  localparam int DWB = 64;
  localparam int AWB = 4;
`ifdef DUAL_RAM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DWA-1:0] i_data_a = '0;
  logic [AWA-1:0] i_addr_a = '0;
  logic           i_wr_en_a = 1'b0;
  logic           i_rd_en_a = 1'b0;
  logic [DWA-1:0] o_data_a;
  logic           o_rd_valid_a;
  logic           i_req_b = 1'b0;
  logic           i_wr_en_b = 1'b0;
  logic [AWB-1:0] i_addr_b = '0;
  logic [DWB-1:0] i_data_b = '0;
  logic           o_ready_b;
  logic [DWB-1:0] o_data_b;
  logic           o_rd_valid_b;
  logic           o_wr_done_b;
  logic           o_conflict;
  logic           o_init_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  asym_dual_ram_sc #(
    .DWA(DWA),
    .AWA(AWA),
    .MULTNUM(MULTNUM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_a     (i_data_a),
    .i_addr_a     (i_addr_a),
    .i_wr_en_a    (i_wr_en_a),
    .i_rd_en_a    (i_rd_en_a),
    .o_data_a     (o_data_a),
    .o_rd_valid_a (o_rd_valid_a),
    .i_req_b      (i_req_b),
    .i_wr_en_b    (i_wr_en_b),
    .i_addr_b     (i_addr_b),
    .i_data_b     (i_data_b),
    .o_ready_b    (o_ready_b),
    .o_data_b     (o_data_b),
    .o_rd_valid_b (o_rd_valid_b),
    .o_wr_done_b  (o_wr_done_b),
    .o_conflict   (o_conflict),
    .o_init_done  (o_init_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle of port-A activity.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [AWA-1:0] addr,
                               input logic [DWA-1:0] data);
    i_wr_en_a = wr;
    i_rd_en_a = rd;
    i_addr_a  = addr;
    i_data_a  = data;
    tick();
    i_wr_en_a = 1'b0;
    i_rd_en_a = 1'b0;
  endtask

  task automatic readA(input logic [AWA-1:0] addr, input logic [DWA-1:0] exp, input string tag);
    applyStimulus(1'b0, 1'b1, addr, '0);
    checkOutput(tag, 64'(o_data_a), 64'(exp));
  endtask

  task automatic requestB(input logic wr, input logic [AWB-1:0] line, input logic [DWB-1:0] data);
    i_req_b   = 1'b1;
    i_wr_en_b = wr;
    i_addr_b  = line;
    i_data_b  = data;
    tick();
    i_req_b   = 1'b0;
  endtask

  // Counts cycles since the accept cycle until the selected pulse; -1 on timeout.
  task automatic waitFlag(input bit rd_sel, input int start, output int cyc);
    cyc = start;
    while (!(rd_sel ? o_rd_valid_b : o_wr_done_b) && cyc < start + 40) begin
      tick();
      cyc++;
    end
    if (!(rd_sel ? o_rd_valid_b : o_wr_done_b)) cyc = -1;
  endtask

  task automatic waitInit();
    int n;
    n = 0;
    while (!o_init_done && n < 200) begin
      tick();
      n++;
    end
    checkOutput("init_wait", 64'(o_init_done), 64'(1));
  endtask

  initial begin
    int cyc;
    int done_count;
    bit conf_seen;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_a", 64'(o_data_a), 64'(0));
    checkOutput("rst_data_b", o_data_b, 64'(0));
    checkOutput("rst_pulses", 64'({o_rd_valid_a, o_rd_valid_b, o_wr_done_b, o_conflict}), 64'(0));
    checkOutput("rst_ready", 64'(o_ready_b), CLEAR_EN ? 64'(0) : 64'(1));
    checkOutput("rst_init_done", 64'(o_init_done), CLEAR_EN ? 64'(0) : 64'(1));
    rst = 1'b0;

`ifdef DUAL_RAM_CLEAR_EN
    // Clear sweep: timing, dropped A write, zero reads during and after.
    begin
      int n;
      n = 0;
      while (!o_init_done && n < 200) begin
        if (n == 3) applyStimulus(1'b1, 1'b0, 6'd5, 16'hFFFF);
        else if (n == 10) begin
          applyStimulus(1'b0, 1'b1, 6'd60, '0);
          checkOutput("clear_rd_zero", 64'(o_data_a), 64'(0));
        end else tick();
        n++;
      end
      checkOutput("clear_latency", 64'(n), 64'(64));
      checkOutput("clear_ready", 64'(o_ready_b), 64'(1));
      for (int i = 0; i < 64; i++) readA(AWA'(i), 16'h0000, "clear_contents");
    end
`endif

    // Test 1: wide write, narrow read-back.
    requestB(1'b1, 4'd2, 64'h4444_3333_2222_1111);
    checkOutput("t1_ready_low", 64'(o_ready_b), 64'(0));
    waitFlag(1'b0, 1, cyc);
    checkOutput("t1_done_latency", 64'(cyc), 64'(5));
    checkOutput("t1_ready_back", 64'(o_ready_b), 64'(1));
    tick();
    checkOutput("t1_done_pulse", 64'(o_wr_done_b), 64'(0));
    readA(6'd8, 16'h1111, "t1_a8");
    checkOutput("t1_rd_valid_a", 64'(o_rd_valid_a), 64'(1));
    readA(6'd9, 16'h2222, "t1_a9");
    readA(6'd10, 16'h3333, "t1_a10");
    readA(6'd11, 16'h4444, "t1_a11");
    tick();
    checkOutput("t1_valid_a_drop", 64'(o_rd_valid_a), 64'(0));
    checkOutput("t1_data_a_hold", 64'(o_data_a), 64'h4444);

    // Test 2: narrow write, wide read.
    applyStimulus(1'b1, 1'b0, 6'd20, 16'hBEEF);
    requestB(1'b0, 4'd5, '0);
    waitFlag(1'b1, 1, cyc);
    checkOutput("t2_valid_latency", 64'(cyc), 64'(5));
    checkOutput("t2_data_b_low", 64'(o_data_b[15:0]), 64'hBEEF);
    if (CLEAR_EN) checkOutput("t2_data_b_full", o_data_b, 64'h0000_0000_0000_BEEF);
    requestB(1'b0, 4'd2, '0);
    waitFlag(1'b1, 1, cyc);
    checkOutput("t2_line2", o_data_b, 64'h4444_3333_2222_1111);
    repeat (3) tick();
    checkOutput("t2_valid_b_drop", 64'(o_rd_valid_b), 64'(0));
    checkOutput("t2_data_b_hold", o_data_b, 64'h4444_3333_2222_1111);

    // Test 3a: A writes to another line stall the B write without conflict.
    requestB(1'b1, 4'd3, 64'hDDDD_CCCC_BBBB_AAAA);
    cyc = 1;
    conf_seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0, 16'(i));
      cyc++;
      if (o_conflict) conf_seen = 1'b1;
    end
    waitFlag(1'b0, cyc, cyc);
    checkOutput("t3_stall_latency", 64'(cyc), 64'(8));
    checkOutput("t3_no_conflict", 64'(conf_seen | o_conflict), 64'(0));
    readA(6'd0, 16'h0003, "t3_a0");
    readA(6'd12, 16'hAAAA, "t3_a12");
    readA(6'd15, 16'hDDDD, "t3_a15");

    // Test 3b: A write into the active line flags a conflict; later B data wins.
    requestB(1'b1, 4'd3, 64'h8888_7777_6666_5555);
    applyStimulus(1'b1, 1'b0, 6'd13, 16'hF00D);
    checkOutput("t3_conflict", 64'(o_conflict), 64'(1));
    tick();
    checkOutput("t3_conflict_drop", 64'(o_conflict), 64'(0));
    waitFlag(1'b0, 3, cyc);
    checkOutput("t3_conf_latency", 64'(cyc), 64'(6));
    readA(6'd13, 16'h6666, "t3_a13_b_wins");

    // Test 4: request held high is not re-accepted while busy.
    i_req_b   = 1'b1;
    i_wr_en_b = 1'b1;
    i_addr_b  = 4'd4;
    i_data_b  = 64'hA4A4_A3A3_A2A2_A1A1;
    done_count = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (o_wr_done_b) done_count++;
    end
    checkOutput("t4_ready_t5", 64'(o_ready_b), 64'(1));
    checkOutput("t4_done_t5", 64'(o_wr_done_b), 64'(1));
    i_req_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_wr_done_b) done_count++;
    end
    checkOutput("t4_done_count", 64'(done_count), 64'(1));
    readA(6'd16, 16'hA1A1, "t4_a16");
    readA(6'd19, 16'hA4A4, "t4_a19");

    // Test 5: reset in the middle of a B write.
    requestB(1'b1, 4'd3, 64'h1212_3434_5656_7878);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t5_ready_on_rst", 64'(o_ready_b), CLEAR_EN ? 64'(0) : 64'(1));
    tick();
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_wr_done_b) done_count++;
      tick();
    end
    checkOutput("t5_no_done", 64'(done_count), 64'(0));
    if (CLEAR_EN) waitInit();
    readA(6'd12, CLEAR_EN ? 16'h0000 : 16'h7878, "t5_a12");
    readA(6'd13, CLEAR_EN ? 16'h0000 : 16'h5656, "t5_a13");
    readA(6'd14, CLEAR_EN ? 16'h0000 : 16'h7777, "t5_a14");
    readA(6'd15, CLEAR_EN ? 16'h0000 : 16'h8888, "t5_a15");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
